// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared opcodes, enums, pipeline register structs and decode helpers
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] { IMM_I, IMM_S, IMM_B, IMM_U, IMM_J } imm_type_t;

    typedef enum logic [1:0] { A_RS1, A_PC, A_ZERO } a_sel_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        alu_op_t     alu_op;
        a_sel_t      a_sel;
        logic        b_imm;
        logic        regwrite;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        regwrite;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        regwrite;
        logic [31:0] wdata;
    } mem_wb_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_t t);
        case (t)
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   return {instr[31:12], 12'b0};
            IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

    // alt is instr[30]; the caller masks it for immediate forms other than SRAI
    function automatic alu_op_t decode_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// rtl/rv32i_alu.sv - combinational integer ALU with branch comparator
module rv32i_alu
    import rv32i_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    input  logic [31:0] cmp_a,
    input  logic [31:0] cmp_b,
    output logic [31:0] result,
    output logic        branch_taken
);

    always_comb begin
        result = 32'h0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = 32'h0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = (cmp_a == cmp_b);
            F3_BNE:  branch_taken = (cmp_a != cmp_b);
            F3_BLT:  branch_taken = ($signed(cmp_a) < $signed(cmp_b));
            F3_BGE:  branch_taken = ($signed(cmp_a) >= $signed(cmp_b));
            F3_BLTU: branch_taken = (cmp_a < cmp_b);
            F3_BGEU: branch_taken = (cmp_a >= cmp_b);
            default: branch_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_pipe_core.sv
// rtl/rv32i_pipe_core.sv - 5-stage in-order RV32I core, stall-only RAW handling, flush on taken control flow
module rv32i_pipe_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction_if,
    output logic [31:0]        pc_if,
    input  logic [31:0]        dmem_rdata,
    output logic               dmem_w_en,
    output logic [31:0]        dmem_wdata,
    output logic [DMEM_AW-1:0] dmem_addr
);

    logic [31:0] pc;
    if_id_t      if_id;
    id_ex_t      id_ex, id_ex_next;
    ex_mem_t     ex_mem, ex_mem_next;
    mem_wb_t     mem_wb, mem_wb_next;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic [2:0]  f3;
    imm_type_t   imm_type;
    logic        use_rs1, use_rs2;
    logic        wb_we;
    logic [31:0] rs1_val, rs2_val;
    logic        haz1, haz2, stall, flush;
    logic [31:0] flush_target;

    assign pc_if  = pc;
    assign opcode = if_id.instr[6:0];
    assign rs1    = if_id.instr[19:15];
    assign rs2    = if_id.instr[24:20];
    assign f3     = if_id.instr[14:12];

    // Register file read with write-through from the WB stage
    assign wb_we   = mem_wb.valid && mem_wb.regwrite && (mem_wb.rd != 5'd0);
    assign rs1_val = (rs1 == 5'd0) ? 32'h0 :
                     (wb_we && mem_wb.rd == rs1) ? mem_wb.wdata : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 :
                     (wb_we && mem_wb.rd == rs2) ? mem_wb.wdata : regs[rs2];

    always_comb begin
        id_ex_next          = '0;
        imm_type            = IMM_I;
        use_rs1             = 1'b0;
        use_rs2             = 1'b0;
        id_ex_next.valid    = if_id.valid;
        id_ex_next.pc       = if_id.pc;
        id_ex_next.rd       = if_id.instr[11:7];
        id_ex_next.funct3   = f3;
        id_ex_next.rs1_data = rs1_val;
        id_ex_next.rs2_data = rs2_val;
        id_ex_next.alu_op   = ALU_ADD;
        id_ex_next.a_sel    = A_RS1;
        id_ex_next.b_imm    = 1'b1;
        case (opcode)
            OP_LUI: begin
                id_ex_next.a_sel    = A_ZERO;
                imm_type            = IMM_U;
                id_ex_next.regwrite = 1'b1;
            end
            OP_AUIPC: begin
                id_ex_next.a_sel    = A_PC;
                imm_type            = IMM_U;
                id_ex_next.regwrite = 1'b1;
            end
            OP_JAL: begin
                id_ex_next.a_sel    = A_PC;
                imm_type            = IMM_J;
                id_ex_next.regwrite = 1'b1;
                id_ex_next.jump     = 1'b1;
            end
            OP_JALR: begin
                id_ex_next.regwrite = 1'b1;
                id_ex_next.jump     = 1'b1;
                id_ex_next.jalr     = 1'b1;
                use_rs1             = 1'b1;
            end
            OP_BRANCH: begin
                id_ex_next.a_sel    = A_PC;
                imm_type            = IMM_B;
                id_ex_next.branch   = 1'b1;
                use_rs1             = 1'b1;
                use_rs2             = 1'b1;
            end
            OP_LOAD: begin
                id_ex_next.regwrite = 1'b1;
                id_ex_next.mem_read = 1'b1;
                use_rs1             = 1'b1;
            end
            OP_STORE: begin
                imm_type             = IMM_S;
                id_ex_next.mem_write = 1'b1;
                use_rs1              = 1'b1;
                use_rs2              = 1'b1;
            end
            OP_IMM: begin
                id_ex_next.alu_op   = decode_alu(f3, (f3 == F3_SR) && if_id.instr[30]);
                id_ex_next.regwrite = 1'b1;
                use_rs1             = 1'b1;
            end
            OP_REG: begin
                id_ex_next.alu_op   = decode_alu(f3, if_id.instr[30]);
                id_ex_next.b_imm    = 1'b0;
                id_ex_next.regwrite = 1'b1;
                use_rs1             = 1'b1;
                use_rs2             = 1'b1;
            end
            default: ;
        endcase
        id_ex_next.imm = gen_imm(if_id.instr, imm_type);
    end

    // WB results are bypassed into ID, so only EX and MEM producers can block
    assign haz1  = use_rs1 && (rs1 != 5'd0) &&
                   ((id_ex.valid && id_ex.regwrite && id_ex.rd == rs1) ||
                    (ex_mem.valid && ex_mem.regwrite && ex_mem.rd == rs1));
    assign haz2  = use_rs2 && (rs2 != 5'd0) &&
                   ((id_ex.valid && id_ex.regwrite && id_ex.rd == rs2) ||
                    (ex_mem.valid && ex_mem.regwrite && ex_mem.rd == rs2));
    assign stall = if_id.valid && (haz1 || haz2);

    logic [31:0] alu_a, alu_b, alu_result;
    logic        br_taken;

    always_comb begin
        alu_a = id_ex.rs1_data;
        case (id_ex.a_sel)
            A_PC:    alu_a = id_ex.pc;
            A_ZERO:  alu_a = 32'h0;
            default: alu_a = id_ex.rs1_data;
        endcase
    end

    assign alu_b = id_ex.b_imm ? id_ex.imm : id_ex.rs2_data;

    rv32i_alu u_alu (
        .alu_op       (id_ex.alu_op),
        .a            (alu_a),
        .b            (alu_b),
        .funct3       (id_ex.funct3),
        .cmp_a        (id_ex.rs1_data),
        .cmp_b        (id_ex.rs2_data),
        .result       (alu_result),
        .branch_taken (br_taken)
    );

    assign flush        = id_ex.valid && (id_ex.jump || (id_ex.branch && br_taken));
    assign flush_target = id_ex.jalr ? {alu_result[31:1], 1'b0} : alu_result;

    always_comb begin
        ex_mem_next           = '0;
        ex_mem_next.valid     = id_ex.valid;
        ex_mem_next.result    = id_ex.jump ? id_ex.pc + 32'd4 : alu_result;
        ex_mem_next.rs2_data  = id_ex.rs2_data;
        ex_mem_next.rd        = id_ex.rd;
        ex_mem_next.funct3    = id_ex.funct3;
        ex_mem_next.regwrite  = id_ex.regwrite;
        ex_mem_next.mem_read  = id_ex.mem_read;
        ex_mem_next.mem_write = id_ex.mem_write;
    end

    logic [1:0]  byte_off;
    logic [31:0] load_shift, load_data, store_data;

    assign byte_off   = ex_mem.result[1:0];
    assign load_shift = dmem_rdata >> {byte_off, 3'b000};
    assign dmem_addr  = ex_mem.result[DMEM_AW+1:2];
    assign dmem_w_en  = ex_mem.valid && ex_mem.mem_write;
    assign dmem_wdata = store_data;

    always_comb begin
        load_data = dmem_rdata;
        case (ex_mem.funct3)
            F3_B:    load_data = {{24{load_shift[7]}}, load_shift[7:0]};
            F3_H:    load_data = {{16{load_shift[15]}}, load_shift[15:0]};
            F3_BU:   load_data = {24'b0, load_shift[7:0]};
            F3_HU:   load_data = {16'b0, load_shift[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // Sub-word stores merge into the word currently read at the same address
    always_comb begin
        store_data = ex_mem.rs2_data;
        if (ex_mem.mem_write && ex_mem.funct3 == F3_B) begin
            store_data = dmem_rdata;
            store_data[{byte_off, 3'b000} +: 8] = ex_mem.rs2_data[7:0];
        end else if (ex_mem.mem_write && ex_mem.funct3 == F3_H) begin
            store_data = dmem_rdata;
            store_data[{byte_off[1], 4'b0000} +: 16] = ex_mem.rs2_data[15:0];
        end
    end

    always_comb begin
        mem_wb_next          = '0;
        mem_wb_next.valid    = ex_mem.valid;
        mem_wb_next.rd       = ex_mem.rd;
        mem_wb_next.regwrite = ex_mem.regwrite;
        mem_wb_next.wdata    = ex_mem.mem_read ? load_data : ex_mem.result;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_PC;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else begin
            if (flush)       pc <= flush_target;
            else if (!stall) pc <= pc + 32'd4;

            if (flush)       if_id <= '0;
            else if (!stall) if_id <= '{valid: 1'b1, pc: pc, instr: instruction_if};

            if (flush || stall) id_ex <= '0;
            else                id_ex <= id_ex_next;

            ex_mem <= ex_mem_next;
            mem_wb <= mem_wb_next;
            if (wb_we) regs[mem_wb.rd] <= mem_wb.wdata;
        end
    end

endmodule

// File: tb/tb_rv32i_pipe_core.sv
// tb/tb_rv32i_pipe_core.sv - directed self-checking bench with async ROM and 64x32 RAM
module tb_rv32i_pipe_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_if;
    logic [31:0] pc_if;
    logic [31:0] dmem_rdata;
    logic        dmem_w_en;
    logic [31:0] dmem_wdata;
    logic [5:0]  dmem_addr;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic        mem_clear = 1'b0;
    logic        tb_we = 1'b0;
    logic [5:0]  tb_wa = 6'd0;
    logic [31:0] tb_wd = 32'h0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign instruction_if = imem[pc_if[7:2]];
    assign dmem_rdata     = dmem[dmem_addr];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
        end else if (tb_we) begin
            dmem[tb_wa] <= tb_wd;
        end else if (dmem_w_en) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
    end

    rv32i_pipe_core #(.RESET_PC(32'h0), .DMEM_AW(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_if (instruction_if),
        .pc_if          (pc_if),
        .dmem_rdata     (dmem_rdata),
        .dmem_w_en      (dmem_w_en),
        .dmem_wdata     (dmem_wdata),
        .dmem_addr      (dmem_addr)
    );

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        int v;
        v = ((imm & 'hFFF) << 20) | ((rs1 & 31) << 15) | ((f3 & 7) << 12) | ((rd & 31) << 7) | (op & 'h7F);
        return v;
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        int v;
        v = (((imm >> 5) & 'h7F) << 25) | ((rs2 & 31) << 20) | ((rs1 & 31) << 15) |
            ((f3 & 7) << 12) | ((imm & 31) << 7) | 'h23;
        return v;
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        int v;
        v = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | ((rs2 & 31) << 20) |
            ((rs1 & 31) << 15) | ((f3 & 7) << 12) | (((imm >> 1) & 'hF) << 8) |
            (((imm >> 11) & 1) << 7) | 'h63;
        return v;
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        int v;
        v = ((f7 & 'h7F) << 25) | ((rs2 & 31) << 20) | ((rs1 & 31) << 15) |
            ((f3 & 7) << 12) | ((rd & 31) << 7) | 'h33;
        return v;
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        int v;
        v = ((imm20 & 'hFFFFF) << 12) | ((rd & 31) << 7) | (op & 'h7F);
        return v;
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        int v;
        v = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) | (((imm >> 11) & 1) << 20) |
            (((imm >> 12) & 'hFF) << 12) | ((rd & 31) << 7) | 'h6F;
        return v;
    endfunction

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 'h13);
    endfunction

    function automatic logic [31:0] sw(int rs2, int imm, int rs1);
        return enc_s(imm, rs2, rs1, 2);
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    endtask

    task automatic begin_reset();
        reset = 1'b0;
        mem_clear = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic end_reset();
        reset = 1'b1;
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic wait_store(input int budget, output logic [5:0] a, output logic [31:0] d, output bit ok);
        ok = 1'b0;
        a = 6'd0;
        d = 32'h0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dmem_w_en === 1'b1) begin
                a = dmem_addr;
                d = dmem_wdata;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_stores(input string name, input int n, input logic [5:0] ea [16], input logic [31:0] ed [16]);
        logic [5:0]  a;
        logic [31:0] d;
        bit          ok;
        for (int i = 0; i < n; i++) begin
            wait_store(40, a, d, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s store%0d: no store seen, expected addr=%0d data=%h", name, i, ea[i], ed[i]);
            end else if (a !== ea[i] || d !== ed[i]) begin
                failures++;
                $display("FAIL %s store%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                         name, i, a, d, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset();
        clear_imem();
        begin_reset();
        checks++;
        if (pc_if !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected %h", pc_if, 32'h0); end
        checks++;
        if (dmem_w_en !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b expected 0", dmem_w_en); end
        checks++;
        if (dmem_addr !== 6'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", dmem_addr); end
        checks++;
        if (dmem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata: got %h expected 0", dmem_wdata); end
        end_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (pc_if !== 32'(4 * i)) begin
                failures++;
                $display("FAIL release_pc%0d: got %h expected %h", i, pc_if, 32'(4 * i));
            end
        end
    endtask

    task automatic test_raw_stall();
        logic [31:0] exp_pc [7] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12, 32'd16};
        logic [5:0]  ea [16];
        logic [31:0] ed [16];
        clear_imem();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 0, 7);
        imem[2] = enc_r(0, 2, 1, 0, 3);
        imem[3] = sw(3, 0, 0);
        begin_reset();
        end_reset();
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (pc_if !== exp_pc[k]) begin
                failures++;
                $display("FAIL raw_pc_k%0d: got %h expected %h", k, pc_if, exp_pc[k]);
            end
        end
        ea[0] = 6'd0; ed[0] = 32'd12;
        expect_stores("raw", 1, ea, ed);
    endtask

    task automatic test_load_store();
        logic [5:0]  ea [16];
        logic [31:0] ed [16];
        clear_imem();
        imem[0] = addi(3, 0, 12);
        imem[1] = sw(3, 8, 0);
        imem[2] = enc_i(8, 0, 2, 4, 'h03);
        imem[3] = sw(4, 12, 0);
        begin_reset();
        end_reset();
        ea[0] = 6'd2; ed[0] = 32'd12;
        ea[1] = 6'd3; ed[1] = 32'd12;
        expect_stores("ldst", 2, ea, ed);
    endtask

    task automatic test_branch();
        logic [5:0]  ea [16];
        logic [31:0] ed [16];
        clear_imem();
        imem[0] = enc_b(12, 0, 0, 0);
        imem[1] = addi(5, 0, 1);
        imem[2] = addi(5, 0, 2);
        imem[3] = sw(5, 16, 0);
        begin_reset();
        end_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (pc_if !== 32'd12) begin failures++; $display("FAIL branch_pc: got %h expected %h", pc_if, 32'd12); end
        ea[0] = 6'd4; ed[0] = 32'h0;
        expect_stores("branch", 1, ea, ed);
    endtask

    task automatic test_alu();
        logic [5:0]  ea [16];
        logic [31:0] ed [16];
        logic [31:0] exp_d [9] = '{32'h1, 32'h0, 32'h8, 32'hA000_0000, 32'h0FFF_FFFF,
                                   32'h5, 32'h2, 32'h0, 32'h7};
        int rsrc [9] = '{3, 4, 5, 6, 9, 8, 10, 11, 12};
        clear_imem();
        imem[0]  = addi(1, 0, -3);
        imem[1]  = addi(2, 0, 5);
        imem[2]  = enc_r(0, 2, 1, 2, 3);
        imem[3]  = enc_r(0, 2, 1, 3, 4);
        imem[4]  = enc_r('h20, 1, 2, 0, 5);
        imem[5]  = enc_r(0, 1, 2, 1, 6);
        imem[6]  = enc_i(4, 1, 5, 9, 'h13);
        imem[7]  = enc_r(0, 2, 1, 7, 8);
        imem[8]  = enc_i(-1, 1, 4, 10, 'h13);
        imem[9]  = enc_b(8, 2, 1, 4);
        imem[10] = addi(11, 0, 1);
        imem[11] = enc_b(8, 2, 1, 6);
        imem[12] = addi(12, 0, 7);
        for (int i = 0; i < 9; i++) begin
            imem[13 + i] = sw(rsrc[i], 4 * i, 0);
            ea[i] = 6'(i);
            ed[i] = exp_d[i];
        end
        begin_reset();
        end_reset();
        expect_stores("alu", 9, ea, ed);
    endtask

    task automatic test_jumps();
        logic [5:0]  ea [16];
        logic [31:0] ed [16];
        clear_imem();
        imem[8]  = enc_j(8, 1);
        imem[9]  = addi(1, 0, 99);
        imem[10] = sw(1, 0, 0);
        imem[11] = enc_u('h12345, 6, 'h37);
        imem[12] = sw(6, 4, 0);
        imem[13] = addi(7, 0, -16);
        imem[14] = enc_i('h402, 7, 5, 8, 'h13);
        imem[15] = sw(8, 8, 0);
        imem[16] = enc_i('h4D, 0, 0, 9, 'h67);
        imem[17] = addi(9, 0, 1);
        imem[18] = addi(9, 0, 2);
        imem[19] = sw(9, 12, 0);
        begin_reset();
        end_reset();
        ea[0] = 6'd0; ed[0] = 32'h0000_0024;
        ea[1] = 6'd1; ed[1] = 32'h1234_5000;
        ea[2] = 6'd2; ed[2] = 32'hFFFF_FFFC;
        ea[3] = 6'd3; ed[3] = 32'h0000_0044;
        expect_stores("jump", 4, ea, ed);
    endtask

    task automatic test_subword();
        logic [5:0]  ea [16];
        logic [31:0] ed [16];
        clear_imem();
        imem[0]  = enc_i('h23, 0, 0, 1, 'h03);
        imem[1]  = enc_i('h23, 0, 4, 2, 'h03);
        imem[2]  = enc_i('h26, 0, 1, 3, 'h03);
        imem[3]  = enc_i('h26, 0, 5, 10, 'h03);
        imem[4]  = enc_i('h24, 0, 0, 11, 'h03);
        imem[5]  = sw(1, 0, 0);
        imem[6]  = sw(2, 4, 0);
        imem[7]  = sw(3, 8, 0);
        imem[8]  = sw(10, 12, 0);
        imem[9]  = sw(11, 16, 0);
        imem[10] = addi(4, 0, 'hAB);
        imem[11] = enc_s('h21, 4, 0, 0);
        imem[12] = enc_s('h26, 4, 0, 1);
        begin_reset();
        poke(6'd8, 32'h1122_3344);
        poke(6'd9, 32'h8899_AABB);
        end_reset();
        ea[0] = 6'd0; ed[0] = 32'h0000_0011;
        ea[1] = 6'd1; ed[1] = 32'h0000_0011;
        ea[2] = 6'd2; ed[2] = 32'hFFFF_8899;
        ea[3] = 6'd3; ed[3] = 32'h0000_8899;
        ea[4] = 6'd4; ed[4] = 32'hFFFF_FFBB;
        ea[5] = 6'd8; ed[5] = 32'h1122_AB44;
        ea[6] = 6'd9; ed[6] = 32'h00AB_AABB;
        expect_stores("subword", 7, ea, ed);
        @(negedge clk);
        checks++;
        if (dmem[8] !== 32'h1122_AB44) begin failures++; $display("FAIL sb_word: got %h expected %h", dmem[8], 32'h1122_AB44); end
        checks++;
        if (dmem[9] !== 32'h00AB_AABB) begin failures++; $display("FAIL sh_word: got %h expected %h", dmem[9], 32'h00AB_AABB); end
    endtask

    task automatic test_mid_reset();
        logic [5:0]  ea [16];
        logic [31:0] ed [16];
        clear_imem();
        imem[0] = addi(1, 0, 9);
        imem[4] = sw(1, 40, 0);
        begin_reset();
        end_reset();
        repeat (6) @(negedge clk);
        begin_reset();
        checks++;
        if (pc_if !== 32'h0 || dmem_w_en !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: got pc=%h wen=%b expected pc=0 wen=0", pc_if, dmem_w_en);
        end
        clear_imem();
        imem[0] = sw(1, 0, 0);
        end_reset();
        ea[0] = 6'd0; ed[0] = 32'h0;
        expect_stores("midreset", 1, ea, ed);
    endtask

    initial begin
        reset = 1'b0;
        clear_imem();
        test_reset();
        test_raw_stall();
        test_load_store();
        test_branch();
        test_alu();
        test_jumps();
        test_subword();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
